// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage: forwarding, ALU, branch resolve, EX/MEM register
//
// Purpose:
//   Consumes the ID/EX register outputs, resolves operand forwarding, runs the
//   ALU, evaluates branch conditions and produces the fetch redirect. Holds the
//   EX/MEM pipeline register that feeds the memory stage.
//
// Optional feature (macro EXEC_MUL_EN):
//   When defined, ALUselE = 4'b1010 performs a two-cycle MUL (low 32 bits of
//   srcA*srcB) sequenced by a small IDLE -> MUL_WAIT -> IDLE FSM. When not
//   defined, 4'b1010 yields 0 and stall_reqE is tied low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   regwriteE..jalrE           single-bit controls from ID/EX
//   wbselE, ALUselE, funct3E   writeback select, ALU op, branch/mem funct3
//   rdE                        destination register
//   rd1E, rd2E, imm_exE        register operands and immediate
//   pcE, pc4E                  PC of this instruction and PC+4
//   forwardAE, forwardBE       forwarding selects from the hazard unit
//   resultW                    writeback-stage value for forwarding
//   stallM, flushM             hold / bubble the EX/MEM register
//   pcsrcE, pc_targetE         redirect request and target to fetch
//   stall_reqE                 multi-cycle op in progress
//   regwriteM..pc4M            EX/MEM register outputs

module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            regwriteE,
  input  logic            memrwE,
  input  logic            brunE,
  input  logic            branchE,
  input  logic            jumpE,
  input  logic            bselE,
  input  logic            jalrE,
  input  logic [1:0]      wbselE,
  input  logic [3:0]      ALUselE,
  input  logic [2:0]      funct3E,
  input  logic [4:0]      rdE,
  input  logic [XLEN-1:0] rd1E,
  input  logic [XLEN-1:0] rd2E,
  input  logic [XLEN-1:0] imm_exE,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] pc4E,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] resultW,
  input  logic            stallM,
  input  logic            flushM,
  output logic            pcsrcE,
  output logic [XLEN-1:0] pc_targetE,
  output logic            stall_reqE,
  output logic            regwriteM,
  output logic            memrwM,
  output logic [1:0]      wbselM,
  output logic [2:0]      funct3M,
  output logic [4:0]      rdM,
  output logic [XLEN-1:0] aluresultM,
  output logic [XLEN-1:0] writedataM,
  output logic [XLEN-1:0] pc4M
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluOut;
  logic [XLEN-1:0] exResult;
  logic [4:0]      shamt;
  logic            aluLtSigned;
  logic            aluLtUnsigned;
  logic            brEq;
  logic            brLt;
  logic            brCond;
  logic [XLEN-1:0] jalrSum;
  logic [XLEN-1:0] branchSum;

  // Operand forwarding; select 11 is not produced by the hazard unit and
  // falls back to the register file value.
  always_comb begin
    srcA = rd1E;
    case (forwardAE)
      2'b01:   srcA = resultW;
      2'b10:   srcA = aluresultM;
      default: srcA = rd1E;
    endcase
  end

  always_comb begin
    fwdB = rd2E;
    case (forwardBE)
      2'b01:   fwdB = resultW;
      2'b10:   fwdB = aluresultM;
      default: fwdB = rd2E;
    endcase
  end

  assign srcB  = bselE ? imm_exE : fwdB;
  assign shamt = srcB[4:0];

  assign aluLtSigned   = $signed(srcA) < $signed(srcB);
  assign aluLtUnsigned = srcA < srcB;

  always_comb begin
    aluOut = '0;
    case (ALUselE)
      ALU_ADD:  aluOut = srcA + srcB;
      ALU_SUB:  aluOut = srcA - srcB;
      ALU_AND:  aluOut = srcA & srcB;
      ALU_OR:   aluOut = srcA | srcB;
      ALU_XOR:  aluOut = srcA ^ srcB;
      ALU_SLL:  aluOut = srcA << shamt;
      ALU_SRL:  aluOut = srcA >> shamt;
      ALU_SRA:  aluOut = $unsigned($signed(srcA) >>> shamt);
      ALU_SLT:  aluOut = {{(XLEN-1){1'b0}}, aluLtSigned};
      ALU_SLTU: aluOut = {{(XLEN-1){1'b0}}, aluLtUnsigned};
      default:  aluOut = '0;
    endcase
  end

  // Branch compare always uses the register operands, never the immediate.
  assign brEq = (srcA == fwdB);
  assign brLt = brunE ? (srcA < fwdB) : ($signed(srcA) < $signed(fwdB));

  always_comb begin
    brCond = 1'b0;
    case (funct3E)
      3'b000:         brCond = brEq;
      3'b001:         brCond = ~brEq;
      3'b100, 3'b110: brCond = brLt;
      3'b101, 3'b111: brCond = ~brLt;
      default:        brCond = 1'b0;
    endcase
  end

  assign pcsrcE     = (branchE & brCond) | jumpE;
  assign jalrSum    = srcA + imm_exE;
  assign branchSum  = pcE + imm_exE;
  assign pc_targetE = jalrE ? (jalrSum & {{(XLEN-1){1'b1}}, 1'b0}) : branchSum;

`ifdef EXEC_MUL_EN
  localparam logic [3:0] ALU_MUL = 4'b1010;

  typedef enum logic {
    IDLE,
    MUL_WAIT
  } mulState_t;

  mulState_t       mulState;
  logic [XLEN-1:0] mulA;
  logic [XLEN-1:0] mulB;
  logic [XLEN-1:0] mulLow;
  logic            isMul;

  assign isMul  = (ALUselE == ALU_MUL);
  assign mulLow = mulA * mulB;

  // Issue cycle: request upstream hold and keep EX/MEM frozen while the
  // operands are latched. A flush or stall defers the issue.
  assign stall_reqE = (mulState == IDLE) & isMul & ~flushM & ~stallM;

  assign exResult = (mulState == MUL_WAIT) ? mulLow : aluOut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulState <= IDLE;
      mulA     <= '0;
      mulB     <= '0;
    end else begin
      case (mulState)
        IDLE: begin
          if (stall_reqE) begin
            mulA     <= srcA;
            mulB     <= srcB;
            mulState <= MUL_WAIT;
          end
        end
        MUL_WAIT: begin
          // A flush aborts; a stall keeps the product pending until EX/MEM
          // is free to take it.
          if (flushM || !stallM) begin
            mulState <= IDLE;
          end
        end
        default: mulState <= IDLE;
      endcase
    end
  end
`else
  assign stall_reqE = 1'b0;
  assign exResult   = aluOut;
`endif

  // EX/MEM pipeline register; flush wins over any hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwriteM  <= 1'b0;
      memrwM     <= 1'b0;
      wbselM     <= 2'b00;
      funct3M    <= 3'b000;
      rdM        <= 5'd0;
      aluresultM <= '0;
      writedataM <= '0;
      pc4M       <= '0;
    end else if (flushM) begin
      regwriteM  <= 1'b0;
      memrwM     <= 1'b0;
      wbselM     <= 2'b00;
      funct3M    <= 3'b000;
      rdM        <= 5'd0;
      aluresultM <= '0;
      writedataM <= '0;
      pc4M       <= '0;
    end else if (!(stallM || stall_reqE)) begin
      regwriteM  <= regwriteE;
      memrwM     <= memrwE;
      wbselM     <= wbselE;
      funct3M    <= funct3E;
      rdM        <= rdE;
      aluresultM <= exResult;
      writedataM <= fwdB;
      pc4M       <= pc4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage

module tb_execute_stage;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [1:0]  wb;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } mOut_t;

  logic clk = 1'b0;
  logic rst_n;
  logic regwriteE, memrwE, brunE, branchE, jumpE, bselE, jalrE;
  logic [1:0]  wbselE;
  logic [3:0]  ALUselE;
  logic [2:0]  funct3E;
  logic [4:0]  rdE;
  logic [31:0] rd1E, rd2E, imm_exE, pcE, pc4E;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] resultW;
  logic        stallM, flushM;
  logic        pcsrcE;
  logic [31:0] pc_targetE;
  logic        stall_reqE;
  logic        regwriteM, memrwM;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic [31:0] aluresultM, writedataM, pc4M;

  mOut_t obs;
  mOut_t modelM;
  mOut_t exp;
  mOut_t sbQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  assign obs = {regwriteM, memrwM, wbselM, funct3M, rdM, aluresultM, writedataM, pc4M};

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .regwriteE(regwriteE), .memrwE(memrwE), .brunE(brunE), .branchE(branchE),
    .jumpE(jumpE), .bselE(bselE), .jalrE(jalrE), .wbselE(wbselE),
    .ALUselE(ALUselE), .funct3E(funct3E), .rdE(rdE), .rd1E(rd1E), .rd2E(rd2E),
    .imm_exE(imm_exE), .pcE(pcE), .pc4E(pc4E), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .resultW(resultW), .stallM(stallM), .flushM(flushM),
    .pcsrcE(pcsrcE), .pc_targetE(pc_targetE), .stall_reqE(stall_reqE),
    .regwriteM(regwriteM), .memrwM(memrwM), .wbselM(wbselM), .funct3M(funct3M),
    .rdM(rdM), .aluresultM(aluresultM), .writedataM(writedataM), .pc4M(pc4M)
  );

  function automatic logic [31:0] mFwd(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'b01) return resultW;
    if (s == 2'b10) return modelM.alu;
    return r;
  endfunction

  function automatic logic [31:0] mAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0: return a + b;
      4'd1: return a + (~b + 32'd1);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd9: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  // Predict the EX/MEM contents after the coming edge and queue them.
  task automatic sbPush();
    logic [31:0] a, b;
    mOut_t n;
    a = mFwd(forwardAE, rd1E);
    b = mFwd(forwardBE, rd2E);
    if (flushM) n = '0;
    else if (stallM) n = modelM;
    else n = '{regwriteE, memrwE, wbselE, funct3E, rdE, mAlu(ALUselE, a, bselE ? imm_exE : b), b, pc4E};
    sbQ.push_back(n);
    modelM = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    {regwriteE, memrwE, brunE, branchE, jumpE, bselE, jalrE} = '0;
    wbselE = 2'b01; ALUselE = 4'd0; funct3E = 3'd0; rdE = 5'd0;
    rd1E = 0; rd2E = 0; imm_exE = 0; pcE = 0; pc4E = 0;
    forwardAE = 0; forwardBE = 0; resultW = 0; stallM = 0; flushM = 0;
  endtask

  task automatic test_reset();
    clearIn();
    rst_n = 1'b0;
    modelM = '0;
    #1;
    testsRun++;
    if (obs !== 108'd0) begin testsFailed++; $display("FAIL reset_state obs=%h exp=0", obs); end
    testsRun++;
    if (stall_reqE !== 1'b0) begin testsFailed++; $display("FAIL reset_stall obs=%b exp=0", stall_reqE); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    for (int op = 0; op < 16; op++) begin
      clearIn();
      ALUselE = op[3:0];
      rd1E = (op % 2 == 0) ? 32'h8000_00F3 : $urandom;
      rd2E = (op == 7) ? 32'd4 : $urandom;
      rdE = op[4:0]; regwriteE = 1; funct3E = 3'd2; pc4E = 32'h400 + op;
      bselE = (op == 5); imm_exE = 32'd35;
      sbPush(); tick();
      exp = sbQ.pop_front();
      testsRun++;
      if (obs !== exp) begin testsFailed++; $display("FAIL alu_op%0d obs=%h exp=%h", op, obs, exp); end
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] want [3];
    want = '{32'd100, 32'd107, 32'd27};
    for (int i = 0; i < 3; i++) begin
      clearIn();
      regwriteE = 1; rdE = 5'd3;
      if (i == 0) begin rd1E = 60; rd2E = 40; end
      else begin rd1E = 5; rd2E = 7; forwardAE = (i == 1) ? 2'b10 : 2'b01; resultW = 20; end
      sbPush(); tick();
      exp = sbQ.pop_front();
      testsRun++;
      if (obs !== exp || aluresultM !== want[i]) begin
        testsFailed++; $display("FAIL fwd_%0d alu=%0d exp=%0d obs=%h", i, aluresultM, want[i], obs);
      end
    end
    // forwardBE from M feeds both the ALU and the store data; 11 falls back.
    clearIn();
    rd1E = 1; rd2E = 9; forwardBE = 2'b10; forwardAE = 2'b11; memrwE = 1;
    sbPush(); tick();
    exp = sbQ.pop_front();
    testsRun++;
    if (obs !== exp || writedataM !== 32'd27 || aluresultM !== 32'd28) begin
      testsFailed++; $display("FAIL fwd_b obs=%h exp=%h", obs, exp);
    end
  endtask

  typedef struct {
    logic br, jmp, jr, un;
    logic [2:0] f3;
    logic [31:0] a, b, pc, imm;
    logic expSrc;
    logic [31:0] expTgt;
  } brCase_t;

  task automatic test_branch();
    brCase_t t [8];
    t[0] = '{1, 0, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 1, 32'h140};
    t[1] = '{1, 0, 0, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 0, 32'h140};
    t[2] = '{1, 0, 0, 0, 3'b000, 32'd7, 32'd7, 32'h200, 32'hFFFF_FFF0, 1, 32'h1F0};
    t[3] = '{1, 0, 0, 0, 3'b001, 32'd7, 32'd7, 32'h200, 32'h8, 0, 32'h208};
    t[4] = '{1, 0, 0, 0, 3'b101, 32'd3, 32'hFFFF_FFFE, 32'h10, 32'h4, 1, 32'h14};
    t[5] = '{1, 0, 0, 1, 3'b111, 32'd3, 32'hFFFF_FFFE, 32'h10, 32'h4, 0, 32'h14};
    t[6] = '{1, 0, 0, 0, 3'b010, 32'd1, 32'd1, 32'hFFFF_FFF0, 32'h20, 0, 32'h10};
    t[7] = '{0, 0, 0, 0, 3'b000, 32'd5, 32'd5, 32'h300, 32'h4, 0, 32'h304};
    clearIn();
    stallM = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      branchE = t[i].br; jumpE = t[i].jmp; jalrE = t[i].jr; brunE = t[i].un;
      funct3E = t[i].f3; rd1E = t[i].a; rd2E = t[i].b; pcE = t[i].pc; imm_exE = t[i].imm;
      #1;
      testsRun++;
      if (pcsrcE !== t[i].expSrc || pc_targetE !== t[i].expTgt) begin
        testsFailed++;
        $display("FAIL branch_%0d pcsrc=%b tgt=%h exp pcsrc=%b tgt=%h", i, pcsrcE, pc_targetE, t[i].expSrc, t[i].expTgt);
      end
    end
    @(posedge clk); #1;
    stallM = 0;
    testsRun++;
    if (obs !== modelM) begin testsFailed++; $display("FAIL branch_hold obs=%h exp=%h", obs, modelM); end
  endtask

  task automatic test_jalr();
    clearIn();
    jalrE = 1; jumpE = 1; rd1E = 32'h1001; imm_exE = 4; pcE = 32'h2000; pc4E = 32'h2004;
    wbselE = 2'b10; regwriteE = 1; rdE = 5'd1; bselE = 1;
    #1;
    testsRun++;
    if (pcsrcE !== 1'b1 || pc_targetE !== 32'h1004) begin
      testsFailed++; $display("FAIL jalr_redirect pcsrc=%b tgt=%h exp 1 00001004", pcsrcE, pc_targetE);
    end
    sbPush(); tick();
    exp = sbQ.pop_front();
    testsRun++;
    if (obs !== exp || wbselM !== 2'b10 || pc4M !== 32'h2004) begin
      testsFailed++; $display("FAIL jalr_mreg obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_flush_stall();
    clearIn();
    regwriteE = 1; memrwE = 1; rd1E = 11; rd2E = 22; rdE = 5'd4;
    sbPush(); tick(); exp = sbQ.pop_front();
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL fs_load obs=%h exp=%h", obs, exp); end
    flushM = 1; stallM = 1;
    sbPush(); tick(); exp = sbQ.pop_front();
    testsRun++;
    if (obs !== exp || regwriteM !== 1'b0 || memrwM !== 1'b0) begin
      testsFailed++; $display("FAIL flush_over_stall obs=%h exp=%h", obs, exp);
    end
    flushM = 0; stallM = 0; rd1E = 33; rdE = 5'd6;
    sbPush(); tick(); exp = sbQ.pop_front();
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL fs_reload obs=%h exp=%h", obs, exp); end
    stallM = 1; rd1E = 99; rdE = 5'd7; memrwE = 0;
    for (int i = 0; i < 2; i++) begin
      sbPush(); tick(); exp = sbQ.pop_front();
      testsRun++;
      if (obs !== exp) begin testsFailed++; $display("FAIL stall_hold_%0d obs=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      clearIn();
      ALUselE = 4'($urandom_range(0, 15));
      if (ALUselE == 4'b1010) ALUselE = 4'b1011;
      rd1E = $urandom; rd2E = $urandom; imm_exE = $urandom; resultW = $urandom;
      pc4E = $urandom; rdE = 5'($urandom); funct3E = 3'($urandom);
      regwriteE = 1'($urandom); memrwE = 1'($urandom); bselE = 1'($urandom);
      wbselE = 2'($urandom); forwardAE = 2'($urandom); forwardBE = 2'($urandom);
      stallM = ($urandom_range(0, 4) == 0); flushM = ($urandom_range(0, 7) == 0);
      sbPush(); tick(); exp = sbQ.pop_front();
      testsRun++;
      if (obs !== exp) begin testsFailed++; $display("FAIL b2b_%0d obs=%h exp=%h", i, obs, exp); end
    end
    clearIn();
  endtask

  task automatic test_reset_mid();
    clearIn();
    regwriteE = 1; rd1E = 5; rdE = 5'd2; pc4E = 32'h44;
    sbPush(); tick(); exp = sbQ.pop_front();
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL pre_reset obs=%h exp=%h", obs, exp); end
    #3;
    rst_n = 0;
    #1;
    testsRun++;
    if (obs !== 108'd0 || stall_reqE !== 1'b0) begin
      testsFailed++; $display("FAIL reset_mid obs=%h stall=%b exp=0", obs, stall_reqE);
    end
    tick();
    rst_n = 1;
    modelM = '0;
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    mOut_t held;
    clearIn();
    ALUselE = 4'b1010; rd1E = 32'h10000; rd2E = 32'h10001; regwriteE = 1; rdE = 5'd9; pc4E = 32'h80;
    #1;
    testsRun++;
    if (stall_reqE !== 1'b1) begin testsFailed++; $display("FAIL mul_issue_stall obs=%b exp=1", stall_reqE); end
    held = modelM;
    tick();
    testsRun++;
    if (obs !== held || stall_reqE !== 1'b0) begin
      testsFailed++; $display("FAIL mul_wait obs=%h stall=%b exp=%h 0", obs, stall_reqE, held);
    end
    sbQ.push_back('{1'b1, 1'b0, 2'b01, 3'd0, 5'd9, 32'h0001_0000, 32'h10001, 32'h80});
    tick();
    exp = sbQ.pop_front(); modelM = exp;
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL mul_result obs=%h exp=%h", obs, exp); end
    rdE = 5'd10;
    tick();
    flushM = 1;
    sbPush(); tick(); exp = sbQ.pop_front();
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL mul_abort obs=%h exp=%h", obs, exp); end
    flushM = 0;
    #1;
    testsRun++;
    if (stall_reqE !== 1'b1) begin testsFailed++; $display("FAIL mul_idle_after_abort obs=%b exp=1", stall_reqE); end
    ALUselE = 4'd0; rd1E = 3; rd2E = 4;
    sbPush(); tick(); exp = sbQ.pop_front();
    testsRun++;
    if (obs !== exp || aluresultM !== 32'd7) begin testsFailed++; $display("FAIL mul_post_add obs=%h exp=%h", obs, exp); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_forwarding();
    test_branch();
    test_jalr();
    test_flush_stall();
    test_back_to_back();
`ifdef EXEC_MUL_EN
    test_mul();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
